// File: rtl/camera_power_seq.sv
// OV5640 power/reset sequencer. A programmable power-up of camera_pwnd and camera_rstn,
// a ready flag once the sensor has settled, and a timed power-down when enable drops.
module camera_power_seq #(
  parameter int CNT_W    = 20,
  parameter int T_OFF    = 135000,
  parameter int T_PWR    = 35000,
  parameter int T_SETTLE = 540000,
  parameter int T_SHDN   = 27
) (
  input  logic       clk_27,
  input  logic       rst_n,
  input  logic       enable,
  output logic       camera_pwnd,
  output logic       camera_rstn,
  output logic       ready,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_OFF_HOLD = 3'd0,
    S_IDLE     = 3'd1,
    S_PWR      = 3'd2,
    S_SETTLE   = 3'd3,
    S_READY    = 3'd4,
    S_SHDN     = 3'd5
  } state_e;

  // A timed state of length T leaves on the edge where the counter holds T-1.
  localparam logic [CNT_W-1:0] OFF_LAST    = CNT_W'(T_OFF - 1);
  localparam logic [CNT_W-1:0] PWR_LAST    = CNT_W'(T_PWR - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(T_SETTLE - 1);
  localparam logic [CNT_W-1:0] SHDN_LAST   = CNT_W'(T_SHDN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pwnd_q, pwnd_d;
  logic             rstn_q, rstn_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             timed;

  always_ff @(posedge clk_27 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF_HOLD;
      cnt_q   <= '0;
      pwnd_q  <= 1'b1;
      rstn_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwnd_q  <= pwnd_d;
      rstn_q  <= rstn_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timed   = 1'b0;
    case (state_q)
      S_OFF_HOLD: begin
        timed = 1'b1;
        if (cnt_q == OFF_LAST) state_d = enable ? S_PWR : S_IDLE;
      end
      S_IDLE: begin
        if (enable) state_d = S_PWR;
      end
      // Losing enable wins over expiry so a dropped request never advances the sequence.
      S_PWR: begin
        timed = 1'b1;
        if (!enable)                state_d = S_SHDN;
        else if (cnt_q == PWR_LAST) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        timed = 1'b1;
        if (!enable)                   state_d = S_SHDN;
        else if (cnt_q == SETTLE_LAST) state_d = S_READY;
      end
      S_READY: begin
        if (!enable) state_d = S_SHDN;
      end
      S_SHDN: begin
        timed = 1'b1;
        if (cnt_q == SHDN_LAST) state_d = S_OFF_HOLD;
      end
      default: state_d = S_OFF_HOLD;
    endcase

    cnt_d = cnt_q;
    if (state_d != state_q)
      cnt_d = '0;
    else if (timed && cnt_q != CNT_MAX)
      cnt_d = cnt_q + 1'b1;

    // Pins are decoded from the next state so they switch on the same edge as the state.
    pwnd_d  = (state_d == S_OFF_HOLD) || (state_d == S_IDLE);
    rstn_d  = (state_d == S_SETTLE) || (state_d == S_READY);
    ready_d = (state_d == S_READY);
    busy_d  = (state_d == S_OFF_HOLD) || (state_d == S_PWR) ||
              (state_d == S_SETTLE) || (state_d == S_SHDN);
  end

  assign camera_pwnd = pwnd_q;
  assign camera_rstn = rstn_q;
  assign ready       = ready_q;
  assign busy        = busy_q;
  assign state       = state_q;

endmodule

// File: tb/tb_camera_power_seq.sv
// Directed bench for camera_power_seq using short delays; expected pin/state vectors are hand-derived.
module tb_camera_power_seq;

  logic       clk_27;
  logic       rst_n;
  logic       enable;
  logic       camera_pwnd;
  logic       camera_rstn;
  logic       ready;
  logic       busy;
  logic [2:0] state;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n;

  // {pwnd, rstn, ready, busy, state}
  localparam logic [6:0] V_OFF  = 7'b1001_000;
  localparam logic [6:0] V_IDLE = 7'b1000_001;
  localparam logic [6:0] V_PWR  = 7'b0001_010;
  localparam logic [6:0] V_SET  = 7'b0101_011;
  localparam logic [6:0] V_RDY  = 7'b0110_100;
  localparam logic [6:0] V_SHDN = 7'b0001_101;

  camera_power_seq #(
    .CNT_W(4), .T_OFF(4), .T_PWR(3), .T_SETTLE(5), .T_SHDN(2)
  ) dut (
    .clk_27(clk_27), .rst_n(rst_n), .enable(enable),
    .camera_pwnd(camera_pwnd), .camera_rstn(camera_rstn),
    .ready(ready), .busy(busy), .state(state)
  );

  initial clk_27 = 1'b0;
  always #5 clk_27 = ~clk_27;

  always @(posedge clk_27 or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  wire [6:0] obs = {camera_pwnd, camera_rstn, ready, busy, state};

  always @(negedge clk_27) begin
    if (rst_n === 1'b1) begin
      n_checks++;
      if ((camera_pwnd === 1'b1 && camera_rstn === 1'b1) ||
          (ready === 1'b1 && !(camera_pwnd === 1'b0 && camera_rstn === 1'b1)))
        $display("FAIL invariant edge=%0d pwnd=%b rstn=%b ready=%b", edge_n, camera_pwnd, camera_rstn, ready);
      else
        n_pass++;
    end
  end

  task automatic wait_edge(input int n);
    int guard = 0;
    while (edge_n < n && guard < 1000) begin
      @(posedge clk_27);
      #1;
      guard++;
    end
    if (edge_n < n) begin
      n_checks++;
      $display("FAIL timeout waiting for edge %0d, at %0d", n, edge_n);
    end
  endtask

  task automatic do_reset(input logic en);
    enable = en;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk_27);
    @(negedge clk_27);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    n_checks++;
    if (obs !== V_OFF) $display("FAIL reset_state got %b want %b", obs, V_OFF);
    else n_pass++;
  endtask

  task automatic test_power_up_down();
    logic [6:0] exp;
    bit chk;
    do_reset(1'b1);
    for (int e = 1; e <= 22; e++) begin
      wait_edge(e);
      chk = 1'b1;
      case (e)
        3:       exp = V_OFF;
        4, 6:    exp = V_PWR;
        7, 11:   exp = V_SET;
        12, 19:  exp = V_RDY;
        20, 21:  exp = V_SHDN;
        22:      exp = V_OFF;
        default: begin exp = '0; chk = 1'b0; end
      endcase
      if (chk) begin
        n_checks++;
        if (obs !== exp) $display("FAIL power_up_down edge=%0d got %b want %b", e, obs, exp);
        else n_pass++;
      end
      if (e == 19) enable = 1'b0;
    end
  endtask

  task automatic test_idle_start();
    logic [6:0] exp;
    bit chk;
    do_reset(1'b0);
    for (int e = 1; e <= 17; e++) begin
      wait_edge(e);
      chk = 1'b1;
      case (e)
        3:       exp = V_OFF;
        4, 8:    exp = V_IDLE;
        9, 11:   exp = V_PWR;
        12, 16:  exp = V_SET;
        17:      exp = V_RDY;
        default: begin exp = '0; chk = 1'b0; end
      endcase
      if (chk) begin
        n_checks++;
        if (obs !== exp) $display("FAIL idle_start edge=%0d got %b want %b", e, obs, exp);
        else n_pass++;
      end
      if (e == 8) enable = 1'b1;
    end
  endtask

  task automatic test_settle_glitch();
    logic [6:0] exp;
    bit chk;
    bit early_ready = 1'b0;
    do_reset(1'b1);
    for (int e = 1; e <= 23; e++) begin
      wait_edge(e);
      if (e < 23 && ready !== 1'b0) early_ready = 1'b1;
      chk = 1'b1;
      case (e)
        8:       exp = V_SET;
        9, 10:   exp = V_SHDN;
        11, 14:  exp = V_OFF;
        15, 17:  exp = V_PWR;
        18, 22:  exp = V_SET;
        23:      exp = V_RDY;
        default: begin exp = '0; chk = 1'b0; end
      endcase
      if (chk) begin
        n_checks++;
        if (obs !== exp) $display("FAIL settle_glitch edge=%0d got %b want %b", e, obs, exp);
        else n_pass++;
      end
      if (e == 8) enable = 1'b0;
      if (e == 9) enable = 1'b1;
    end
    n_checks++;
    if (early_ready) $display("FAIL settle_glitch_early_ready got 1 want 0");
    else n_pass++;
  endtask

  task automatic test_pwr_expiry_priority();
    logic [6:0] exp;
    bit chk;
    bit saw_rstn = 1'b0;
    do_reset(1'b1);
    for (int e = 1; e <= 13; e++) begin
      wait_edge(e);
      if (camera_rstn !== 1'b0) saw_rstn = 1'b1;
      chk = 1'b1;
      case (e)
        6:       exp = V_PWR;
        7, 8:    exp = V_SHDN;
        9, 12:   exp = V_OFF;
        13:      exp = V_IDLE;
        default: begin exp = '0; chk = 1'b0; end
      endcase
      if (chk) begin
        n_checks++;
        if (obs !== exp) $display("FAIL pwr_expiry edge=%0d got %b want %b", e, obs, exp);
        else n_pass++;
      end
      if (e == 6) enable = 1'b0;
    end
    n_checks++;
    if (saw_rstn) $display("FAIL pwr_expiry_rstn got 1 want 0");
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    wait_edge(12);
    n_checks++;
    if (obs !== V_RDY) $display("FAIL async_pre got %b want %b", obs, V_RDY);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== V_OFF) $display("FAIL async_reset got %b want %b", obs, V_OFF);
    else n_pass++;
    @(negedge clk_27);
    rst_n = 1'b1;
    wait_edge(4);
    n_checks++;
    if (obs !== V_PWR) $display("FAIL async_rerun_pwr got %b want %b", obs, V_PWR);
    else n_pass++;
    wait_edge(12);
    n_checks++;
    if (obs !== V_RDY) $display("FAIL async_rerun_ready got %b want %b", obs, V_RDY);
    else n_pass++;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    test_reset();
    test_power_up_down();
    test_idle_start();
    test_settle_glitch();
    test_pwr_expiry_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
